// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch: requests one word from instruction memory, holds it for
//   decode until consumed, then requests the next sequential word. A redirect
//   (branch/jump) restarts fetching at a new address and discards any work in
//   flight.
//
//   Optional feature, enabled by defining FETCH_ALIGN_CHECK_EN:
//     a misaligned redirect target raises fetch_fault and parks the stage in a
//     FAULT state until an aligned redirect arrives. When the macro is not
//     defined, redirect targets are word-aligned by clearing bits [1:0] and
//     fetch_fault is constant 0.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   imem_req     out  1   read request to instruction memory
//   imem_addr    out  32  address being fetched (the PC)
//   imem_ack     in   1   imem_rdata valid for the current request
//   imem_rdata   in   32  instruction word from memory
//   instr        out  32  held instruction word
//   instr_pc     out  32  address of the held instruction
//   instr_valid  out  1   instr/instr_pc valid for decode
//   instr_ready  in   1   decode consumes the held instruction this cycle
//   redirect     in   1   restart fetch at redirect_pc
//   redirect_pc  in   32  restart address
//   fetch_fault  out  1   misaligned redirect seen (alignment check only)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    ST_FAULT = 2'd2
`endif
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] instr_pc_reg, instr_pc_next;
  logic        valid_reg, valid_next;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault_reg, fault_next;
`else
  // Low address bits are discarded when the alignment check is absent.
  logic        unused_align;
  assign unused_align = ^redirect_pc[1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_REQ;
      pc_reg       <= RESET_PC;
      instr_reg    <= NOP;
      instr_pc_reg <= RESET_PC;
      valid_reg    <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_reg    <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      instr_pc_reg <= instr_pc_next;
      valid_reg    <= valid_next;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_reg    <= fault_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;
    valid_next    = valid_reg;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_next    = fault_reg;
`endif

    if (redirect) begin
      // Redirect wins over everything: a same-cycle ack is dropped and a
      // same-cycle consume does not advance the PC.
      valid_next = 1'b0;
      state_next = ST_REQ;
`ifdef FETCH_ALIGN_CHECK_EN
      pc_next    = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        fault_next = 1'b1;
        state_next = ST_FAULT;
      end else begin
        fault_next = 1'b0;
      end
`else
      pc_next    = {redirect_pc[31:2], 2'b00};
`endif
    end else begin
      unique case (state_reg)
        ST_REQ: begin
          if (imem_ack) begin
            instr_next    = imem_rdata;
            instr_pc_next = pc_reg;
            valid_next    = 1'b1;
            state_next    = ST_HOLD;
          end
        end
        ST_HOLD: begin
          // instr_valid is always 1 in HOLD, so a consume here is never
          // one of the ignored "ready while not valid" cases.
          if (instr_ready) begin
            pc_next    = pc_reg + 32'd4;
            valid_next = 1'b0;
            state_next = ST_REQ;
          end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        ST_FAULT: begin
          // Only an aligned redirect (handled above) leaves this state.
        end
`endif
        default: state_next = ST_REQ;
      endcase
    end
  end

  assign imem_req    = (state_reg == ST_REQ);
  assign imem_addr   = pc_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = valid_reg;
`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_fault = fault_reg;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. A small memory responder acks requests on
//   command; each acked word is pushed onto a scoreboard with the address it
//   was fetched from and popped when decode sees instr_valid.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } txn_t;

  txn_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] last_instr;
  logic [31:0] last_pc;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Fetch one word at exp_pc: wait 'delay' cycles before acking, keep decode
  // stalled for 'hold' cycles, then consume.
  task automatic fetch_one(input logic [31:0] data, input int delay, input int hold);
    txn_t t;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_addr", imem_addr, exp_pc);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("req", {31'd0, imem_req}, 32'd1);
    check("addr", imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = data;
    sb.push_back('{pc: exp_pc, ins: data});
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    @(negedge clk);
    check("valid_after_ack", {31'd0, instr_valid}, 32'd1);
    check("req_in_hold", {31'd0, imem_req}, 32'd0);
    check("sb_size", sb.size(), 32'd1);
    if (sb.size() > 0) begin
      t = sb.pop_front();
      check("instr", instr, t.ins);
      check("instr_pc", instr_pc, t.pc);
      $display("txn pc=%h instr=%h", instr_pc, instr);
      last_instr = t.ins;
      last_pc    = t.pc;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_instr", instr, last_instr);
      check("hold_pc", instr_pc, last_pc);
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_req", {31'd0, imem_req}, 32'd0);
    end
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic do_redirect(input logic [31:0] a, input logic ack, input logic rdy);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = a;
    imem_ack    = ack;
    imem_rdata  = 32'hDEAD_BEEF;
    instr_ready = rdy;
    @(posedge clk); #1;
    redirect    = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    imem_ack    = 1'b1;  // acks during reset must be ignored
    imem_rdata  = 32'h1234_5678;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    exp_pc      = 32'h0;
    last_instr  = 32'h0000_0013;
    last_pc     = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    rst        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;

    // Back-to-back sequential fetches at 0,4,8
    for (int i = 0; i < 3; i++) fetch_one(32'hFFC4_A303, 0, 0);

    // Delayed ack (5 cycles) and decode stalled for 4 cycles
    fetch_one(32'h0010_0093, 5, 4);

    // Redirect together with an ack: ack dropped, fetch restarts at 0x100
    do_redirect(32'h0000_0100, 1'b1, 1'b0);
    @(negedge clk);
    check("redir_ack_valid", {31'd0, instr_valid}, 32'd0);
    check("redir_ack_instr", instr, last_instr);
    check("redir_ack_addr", imem_addr, 32'h0000_0100);
    exp_pc = 32'h0000_0100;
    fetch_one(32'h0020_0113, 0, 0);

    // Redirect together with a consume in HOLD: pc goes to target, not +4
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0030_0193;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    @(negedge clk);
    check("pre_redir_valid", {31'd0, instr_valid}, 32'd1);
    do_redirect(32'h0000_0200, 1'b0, 1'b1);
    @(negedge clk);
    check("redir_rdy_addr", imem_addr, 32'h0000_0200);
    check("redir_rdy_valid", {31'd0, instr_valid}, 32'd0);
    exp_pc = 32'h0000_0200;
    fetch_one(32'h0040_0213, 1, 1);

    // PC wrap at the top of the address space
    do_redirect(32'hFFFF_FFFC, 1'b0, 1'b0);
    exp_pc = 32'hFFFF_FFFC;
    fetch_one(32'h0050_0293, 0, 0);
    check("wrap_exp", exp_pc, 32'h0);
    fetch_one(32'h0060_0313, 0, 0);

    // Misaligned redirect
`ifdef FETCH_ALIGN_CHECK_EN
    do_redirect(32'h0000_0102, 1'b0, 1'b0);
    @(negedge clk);
    check("fault_set", {31'd0, fetch_fault}, 32'd1);
    check("fault_req", {31'd0, imem_req}, 32'd0);
    check("fault_valid", {31'd0, instr_valid}, 32'd0);
    do_redirect(32'h0000_0103, 1'b0, 1'b0);
    @(negedge clk);
    check("fault_stay", {31'd0, fetch_fault}, 32'd1);
    check("fault_stay_req", {31'd0, imem_req}, 32'd0);
    do_redirect(32'h0000_0104, 1'b0, 1'b0);
    @(negedge clk);
    check("fault_clear", {31'd0, fetch_fault}, 32'd0);
    check("fault_exit_addr", imem_addr, 32'h0000_0104);
    exp_pc = 32'h0000_0104;
`else
    do_redirect(32'h0000_0102, 1'b0, 1'b0);
    @(negedge clk);
    check("align_addr", imem_addr, 32'h0000_0100);
    check("align_fault", {31'd0, fetch_fault}, 32'd0);
    check("align_req", {31'd0, imem_req}, 32'd1);
    exp_pc = 32'h0000_0100;
`endif
    fetch_one(32'h0070_0393, 0, 0);

    // Reset asserted mid-request, with an ack pending
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    rst        = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_rst_instr", instr, 32'h0000_0013);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_instr_pc", instr_pc, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_hold_valid", {31'd0, instr_valid}, 32'd0);
    @(posedge clk); #1;
    rst        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    exp_pc     = 32'h0;
    fetch_one(32'h0080_0413, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
